instruction_fetch_controller: RTL and testbench
===============================================

# instruction_fetch_controller

Sequences the instruction memory for the RV32IM pipeline. The block owns the program counter and drives the memory address every cycle. It captures each returned word into a 4-entry fetch queue and hands {PC, instruction} pairs to the IF/ID stage over a valid/ready handshake. It sits between `INSTRUCTION_MEMORY` (combinational read) and the decode stage, and absorbs decode stalls and branch/jump redirects from EX.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `DEPTH`, default 4, fetch queue entries; power of two, 2..16.
- `NOP_WORD`, default 32'h0000_0013, value driven on `OUT_INSTRUCTION` when the queue is empty (ADDI x0,x0,0).
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `FETCH_EN`  in  1  1 = fetching allowed; 0 = hold PC, no enqueue (drain continues).
- `IMEM_ADDRESS`  out  32  byte address presented to instruction memory; always equals PC.
- `IMEM_INSTRUCTION`  in  32  instruction word for `IMEM_ADDRESS`, valid in the same cycle.
- `IMEM_READY`  in  1  memory port available this cycle (0 = port lent to loader/debug).
- `BRANCH_TAKEN`  in  1  redirect request from EX, single-cycle pulse.
- `BRANCH_TARGET`  in  32  redirect byte address.
- `OUT_VALID`  out  1  queue head holds a valid instruction.
- `OUT_READY`  in  1  decode accepts the head this cycle.
- `OUT_INSTRUCTION`  out  32  queue head instruction; `NOP_WORD` when empty.
- `OUT_PC`  out  32  PC of queue head; 0 when empty.
- `QUEUE_COUNT`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State: `PC`, circular queue (`DEPTH` × {pc, instr}), read/write pointers of width $clog2(DEPTH), and `count`.
- Derived signals, all combinational from current state and inputs:
  - `deq = OUT_VALID & OUT_READY`
  - `enq = FETCH_EN & IMEM_READY & ~BRANCH_TAKEN & (count < DEPTH)`
- The full check uses the current `count`. When full, an enqueue is never allowed, even if a dequeue happens in the same cycle.
- On `enq`: write {PC, IMEM_INSTRUCTION} at the write pointer, advance the write pointer, PC ← PC + 4.
  - PC addition is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - Pointers wrap modulo `DEPTH`.
- On `deq`: advance the read pointer.
- `count` next value:
  - `count + enq − deq` normally.
  - simultaneous `enq` and `deq`: `count` unchanged.
- Redirect (`BRANCH_TAKEN`=1) has priority over everything:
  - Queue is flushed: both pointers ← 0, `count` ← 0.
  - PC ← {BRANCH_TARGET[31:2], 2'b00}; low two bits are silently cleared.
  - No enqueue in that cycle.
  - A `deq` in the same cycle still counts as accepted by decode; the flush discards the remaining entries.
- Controller states (derived, not separately encoded):
  - FETCH: `enq`=1.
  - STALL: full, `IMEM_READY`=0, or `FETCH_EN`=0. PC holds.
  - REDIRECT: `BRANCH_TAKEN`=1.
- `OUT_VALID = (count != 0)`.
- `OUT_INSTRUCTION` and `OUT_PC` are muxed from the head entry. They hold steady while `OUT_VALID`=1 and `OUT_READY`=0.

## Timing
- Reset values (`RESET`=0 at an edge):
  - PC = `RESET_PC`, so `IMEM_ADDRESS` = `RESET_PC`.
  - `count` = 0, `OUT_VALID` = 0, `OUT_INSTRUCTION` = `NOP_WORD`, `OUT_PC` = 0, `QUEUE_COUNT` = 0.
  - Queue contents are don't-care.
- Reset mid-operation has the same effect as a flush plus PC ← `RESET_PC`. Reset has priority over `BRANCH_TAKEN`.
- Fetch-to-output latency: 1 cycle. A word enqueued at edge N is visible on `OUT_*` after edge N when the queue was empty (no combinational bypass).
- Throughput: 1 instruction per cycle sustained while `OUT_READY`=1.
- Redirect: target word appears on `OUT_*` 2 edges after the `BRANCH_TAKEN` edge. That is one bubble with `OUT_VALID`=0, then the target.
- `IMEM_ADDRESS` changes only at clock edges. There is no combinational path from `BRANCH_TAKEN` or `OUT_READY` to `IMEM_ADDRESS`.

## Test plan
- **Reset and free run:** `RESET` low 2 cycles then high, `RESET_PC`=0, memory holds NOPs with ADD x3,x1,x2 (32'h0020_81B3) at 36, `OUT_READY`=1.
  - Required: `OUT_PC` sequence 0,4,8,… one per cycle starting 1 cycle after release.
  - Required: `OUT_INSTRUCTION`=32'h0020_81B3 when `OUT_PC`=36.
- **Backpressure/full:** `OUT_READY`=0 for 8 cycles after reset.
  - Required: `QUEUE_COUNT` reaches 4 and holds; `IMEM_ADDRESS` freezes at 16; head stays PC 0.
  - Then `OUT_READY`=1: PCs 0,4,8,12,16,20 delivered with no gap and no duplicate.
- **Redirect with full queue:** queue full at PCs 0–12, pulse `BRANCH_TAKEN` with target 32'h0000_0046.
  - Required: next cycle `QUEUE_COUNT`=0, `OUT_VALID`=0, `IMEM_ADDRESS`=32'h44.
  - Required: following cycle `OUT_PC`=32'h44 (misaligned target's low bits cleared).
- **Memory port lending:** toggle `IMEM_READY` 1,0,0,1 with `OUT_READY`=1.
  - Required: PC advances only in READY cycles; `OUT_VALID` drops for exactly the two cycles after the stalled edges.
- **Wrap and mid-run reset:**
  - Redirect to 32'hFFFF_FFFC: `OUT_PC` sequence FFFF_FFFC then 0000_0000.
  - Assert `RESET` during a concurrent `BRANCH_TAKEN`: PC = `RESET_PC`, queue empty, `OUT_INSTRUCTION` = 32'h0000_0013.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, fills a circular fetch queue from a
// combinational instruction memory and presents {pc, instr} pairs to decode.
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FETCH_EN,
    output logic [31:0]                IMEM_ADDRESS,
    input  logic [31:0]                IMEM_INSTRUCTION,
    input  logic                       IMEM_READY,
    input  logic                       BRANCH_TAKEN,
    input  logic [31:0]                BRANCH_TARGET,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [31:0]                OUT_INSTRUCTION,
    output logic [31:0]                OUT_PC,
    output logic [$clog2(DEPTH):0]     QUEUE_COUNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        FETCH,
        STALL,
        REDIRECT
    } ctrl_e;

    logic [31:0]   pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          deq;
    logic          enq;
    ctrl_e         ctrl;

    // Full check uses the current count, so a same-cycle dequeue never frees a slot.
    always_comb begin
        OUT_VALID = (count != '0);
        deq       = OUT_VALID & OUT_READY;
        enq       = FETCH_EN & IMEM_READY & ~BRANCH_TAKEN & (count < CW'(DEPTH));
        if (BRANCH_TAKEN)
            ctrl = REDIRECT;
        else if (enq)
            ctrl = FETCH;
        else
            ctrl = STALL;
    end

    always_comb begin
        IMEM_ADDRESS    = pc;
        QUEUE_COUNT     = count;
        OUT_INSTRUCTION = OUT_VALID ? q_instr[rd_ptr] : NOP_WORD;
        OUT_PC          = OUT_VALID ? q_pc[rd_ptr]    : '0;
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= IMEM_INSTRUCTION;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            case (ctrl)
                REDIRECT: begin
                    pc     <= {BRANCH_TARGET[31:2], 2'b00};
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end
                FETCH: begin
                    pc     <= pc + 32'd4;
                    wr_ptr <= wr_ptr + PW'(1);
                    if (deq)
                        rd_ptr <= rd_ptr + PW'(1);
                    else
                        count <= count + CW'(1);
                end
                default: begin
                    if (deq) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        count  <= count - CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller: directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_instruction_fetch_controller;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] ADD_WORD = 32'h0020_81B3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FETCH_EN = 1'b0;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_INSTRUCTION;
    logic        IMEM_READY = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_INSTRUCTION;
    logic [31:0] OUT_PC;
    logic [2:0]  QUEUE_COUNT;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic        mem_mode = 1'b0;

    instruction_fetch_controller #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .FETCH_EN         (FETCH_EN),
        .IMEM_ADDRESS     (IMEM_ADDRESS),
        .IMEM_INSTRUCTION (IMEM_INSTRUCTION),
        .IMEM_READY       (IMEM_READY),
        .BRANCH_TAKEN     (BRANCH_TAKEN),
        .BRANCH_TARGET    (BRANCH_TARGET),
        .OUT_VALID        (OUT_VALID),
        .OUT_READY        (OUT_READY),
        .OUT_INSTRUCTION  (OUT_INSTRUCTION),
        .OUT_PC           (OUT_PC),
        .QUEUE_COUNT      (QUEUE_COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic mode);
        if (a == 32'd36) return ADD_WORD;
        if (!mode) return NOP_WORD;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    always_comb IMEM_INSTRUCTION = mem_word(IMEM_ADDRESS, mem_mode);

    // Reference model: PC plus a FIFO of fetched {pc, instr} pairs.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;

    task automatic model_step(input logic rst, fen, irdy, br, input logic [31:0] tgt,
                              input logic rdy);
        ent_t e;
        logic do_enq;
        logic do_deq;
        if (!rst) begin
            m_pc = RESET_PC;
            mq.delete();
        end else if (br) begin
            mq.delete();
            m_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            do_deq = (mq.size() != 0) && rdy;
            do_enq = fen && irdy && (mq.size() < DEPTH);
            if (do_deq) void'(mq.pop_front());
            if (do_enq) begin
                e.pc  = m_pc;
                e.ins = mem_word(m_pc, mem_mode);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic rst, fen, irdy, br, input logic [31:0] tgt,
                        input logic rdy);
        RESET = rst; FETCH_EN = fen; IMEM_READY = irdy;
        BRANCH_TAKEN = br; BRANCH_TARGET = tgt; OUT_READY = rdy;
        @(posedge CLK);
        model_step(rst, fen, irdy, br, tgt, rdy);
        #1;
    endtask

    task automatic check_model();
        logic        v;
        logic [31:0] epc;
        logic [31:0] ein;
        v   = (mq.size() != 0);
        epc = v ? mq[0].pc  : 32'd0;
        ein = v ? mq[0].ins : NOP_WORD;
        chk("rnd_valid", {31'd0, OUT_VALID}, {31'd0, v});
        chk("rnd_pc", OUT_PC, epc);
        chk("rnd_instr", OUT_INSTRUCTION, ein);
        chk("rnd_addr", IMEM_ADDRESS, m_pc);
        chk("rnd_count", {29'd0, QUEUE_COUNT}, mq.size());
    endtask

    typedef struct {
        logic        rst, fen, irdy, br;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, rdy, br, input logic [31:0] tgt,
                                input logic ev, input logic [31:0] epc, eaddr,
                                input logic [2:0] ecnt);
        vec_t r;
        r.rst = rst; r.fen = 1'b1; r.irdy = 1'b1; r.br = br; r.tgt = tgt; r.rdy = rdy;
        r.e_valid = ev; r.e_pc = epc; r.e_addr = eaddr; r.e_cnt = ecnt;
        return r;
    endfunction

    initial begin
        // Backpressure/full, then release; then redirect out of a full queue.
        vt.push_back(mk(0, 0, 0, 0, 0, 32'd0,  32'd0,  3'd0));
        vt.push_back(mk(0, 0, 0, 0, 0, 32'd0,  32'd0,  3'd0));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd4,  3'd1));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd8,  3'd2));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd12, 3'd3));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd16, 3'd4));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd16, 3'd4));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd16, 3'd4));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd16, 3'd4));
        vt.push_back(mk(1, 1, 0, 0, 1, 32'd4,  32'd16, 3'd3));
        vt.push_back(mk(1, 1, 0, 0, 1, 32'd8,  32'd20, 3'd3));
        vt.push_back(mk(1, 1, 0, 0, 1, 32'd12, 32'd24, 3'd3));
        vt.push_back(mk(1, 1, 0, 0, 1, 32'd16, 32'd28, 3'd3));
        vt.push_back(mk(1, 1, 0, 0, 1, 32'd20, 32'd32, 3'd3));
        vt.push_back(mk(0, 0, 0, 0, 0, 32'd0,  32'd0,  3'd0));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd4,  3'd1));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd8,  3'd2));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd12, 3'd3));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'd0,  32'd16, 3'd4));
        vt.push_back(mk(1, 0, 1, 32'h46, 0, 32'd0, 32'h44, 3'd0));
        vt.push_back(mk(1, 0, 0, 0, 1, 32'h44, 32'h48, 3'd1));

        for (int i = 0; i < vt.size(); i++) begin
            tick(vt[i].rst, vt[i].fen, vt[i].irdy, vt[i].br, vt[i].tgt, vt[i].rdy);
            chk($sformatf("vec%0d_valid", i), {31'd0, OUT_VALID}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_pc", i), OUT_PC, vt[i].e_pc);
            chk($sformatf("vec%0d_addr", i), IMEM_ADDRESS, vt[i].e_addr);
            chk($sformatf("vec%0d_count", i), {29'd0, QUEUE_COUNT}, {29'd0, vt[i].e_cnt});
        end

        // Free run from reset, NOP memory with ADD at 36.
        tick(0, 1, 1, 0, 0, 1);
        chk("reset_instr", OUT_INSTRUCTION, NOP_WORD);
        chk("reset_pc", OUT_PC, 32'd0);
        tick(0, 1, 1, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            tick(1, 1, 1, 0, 0, 1);
            chk("run_valid", {31'd0, OUT_VALID}, 32'd1);
            chk("run_pc", OUT_PC, 32'(4 * k));
            chk("run_instr", OUT_INSTRUCTION, (k == 9) ? ADD_WORD : NOP_WORD);
        end

        // Memory port lending: head 44, PC 48 at this point.
        tick(1, 1, 1, 0, 0, 1);
        chk("lend0_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("lend0_pc", OUT_PC, 32'd48);
        chk("lend0_addr", IMEM_ADDRESS, 32'd52);
        tick(1, 1, 0, 0, 0, 1);
        chk("lend1_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("lend1_addr", IMEM_ADDRESS, 32'd52);
        tick(1, 1, 0, 0, 0, 1);
        chk("lend2_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("lend2_addr", IMEM_ADDRESS, 32'd52);
        tick(1, 1, 1, 0, 0, 1);
        chk("lend3_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("lend3_pc", OUT_PC, 32'd52);
        chk("lend3_addr", IMEM_ADDRESS, 32'd56);

        // PC wrap across 2^32.
        tick(1, 1, 1, 1, 32'hFFFF_FFFC, 1);
        chk("wrap_bubble", {31'd0, OUT_VALID}, 32'd0);
        chk("wrap_addr0", IMEM_ADDRESS, 32'hFFFF_FFFC);
        tick(1, 1, 1, 0, 0, 1);
        chk("wrap_pc0", OUT_PC, 32'hFFFF_FFFC);
        chk("wrap_addr1", IMEM_ADDRESS, 32'h0000_0000);
        tick(1, 1, 1, 0, 0, 1);
        chk("wrap_pc1", OUT_PC, 32'h0000_0000);
        chk("wrap_addr2", IMEM_ADDRESS, 32'h0000_0004);

        // Reset wins over a concurrent redirect.
        tick(0, 1, 1, 1, 32'h0000_0100, 0);
        chk("rstbr_addr", IMEM_ADDRESS, RESET_PC);
        chk("rstbr_count", {29'd0, QUEUE_COUNT}, 32'd0);
        chk("rstbr_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rstbr_instr", OUT_INSTRUCTION, 32'h0000_0013);

        // Randomized run against the model.
        mem_mode = 1'b1;
        tick(0, 0, 0, 0, 0, 0);
        check_model();
        for (int n = 0; n < 2000; n++) begin
            tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                 $urandom(), $urandom_range(0, 1) == 1);
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
